// File: rtl/riscv_dmem_bus_bridge.sv
// ----------------------------------------------------------------------------
// riscv_dmem_bus_bridge
//
// Purpose:
//   Bridges the pipeline CPU's data-memory port onto a variable-latency
//   request/grant/response bus. Each CPU load or store is latched into the
//   bus request registers and the CPU is stalled until the response returns.
//   The access then retires in a single DONE cycle. A response timeout
//   guarantees forward progress: a hung response is forced complete and
//   flagged as an error.
//
// Ports:
//   i_clk, i_rst            clock (rising edge), asynchronous active-high reset
//   i_bridge_*              CPU access: addr, wr_en, rd_en, byte_sel, wr_data
//   o_bridge_rd_data        load data returned to the CPU (held between loads)
//   o_bridge_stall          holds the CPU pipeline while an access is in flight
//   o_bridge_err            one-cycle pulse in DONE on bus error or timeout
//   o_bridge_err_sticky     accumulates every error until reset
//   o_bus_req/we/addr/be/wdata   bus request side (word-aligned address)
//   i_bus_gnt               bus accepted the request this cycle
//   i_bus_rvalid/rdata/err  bus response (reads and writes both respond)
// ----------------------------------------------------------------------------
module riscv_dmem_bus_bridge #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_bridge_addr,
  input  logic            i_bridge_wr_en,
  input  logic            i_bridge_rd_en,
  input  logic [3:0]      i_bridge_byte_sel,
  input  logic [XLEN-1:0] i_bridge_wr_data,
  output logic [XLEN-1:0] o_bridge_rd_data,
  output logic            o_bridge_stall,
  output logic            o_bridge_err,
  output logic            o_bridge_err_sticky,
  output logic            o_bus_req,
  output logic            o_bus_we,
  output logic [XLEN-1:0] o_bus_addr,
  output logic [3:0]      o_bus_be,
  output logic [XLEN-1:0] o_bus_wdata,
  input  logic            i_bus_gnt,
  input  logic            i_bus_rvalid,
  input  logic [XLEN-1:0] i_bus_rdata,
  input  logic            i_bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Last counter value of the response window; reaching it without rvalid
  // forces the access complete.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            err_flag_q, err_flag_d;
  logic            sticky_q, sticky_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  logic access;

  // The bus is word addressed; the CPU's byte offset is carried by byte_sel.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^i_bridge_addr[1:0];

  assign access = i_bridge_rd_en | i_bridge_wr_en;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      err_flag_q <= 1'b0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      err_flag_q <= err_flag_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    err_flag_d = err_flag_q;
    sticky_d   = sticky_q;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: begin
        if (access) begin
          state_d = REQ;
          req_d   = 1'b1;
          // A simultaneous rd_en/wr_en is treated as a store.
          we_d    = i_bridge_wr_en;
          addr_d  = {i_bridge_addr[XLEN-1:2], 2'b00};
          be_d    = i_bridge_byte_sel;
          wdata_d = i_bridge_wr_data;
        end
      end

      REQ: begin
        if (i_bus_gnt) begin
          req_d = 1'b0;
          cnt_d = '0;
          if (i_bus_rvalid) begin
            // Zero-latency response: skip RSP entirely.
            if (!we_q) rd_data_d = i_bus_rdata;
            err_flag_d = i_bus_err;
            state_d    = DONE;
          end else begin
            state_d = RSP;
          end
        end
      end

      RSP: begin
        // rvalid wins over a timeout landing in the same cycle.
        if (i_bus_rvalid) begin
          if (!we_q) rd_data_d = i_bus_rdata;
          err_flag_d = i_bus_err;
          state_d    = DONE;
        end else if (cnt_q == TO_LAST) begin
          rd_data_d  = '0;
          err_flag_d = 1'b1;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        // The access still visible here is the one retiring; the next one
        // is picked up from IDLE.
        sticky_d = sticky_q | err_flag_q;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_bridge_stall      = ((state_q == IDLE) & access) |
                               (state_q == REQ) | (state_q == RSP);
  assign o_bridge_err        = (state_q == DONE) & err_flag_q;
  assign o_bridge_err_sticky = sticky_q;
  assign o_bridge_rd_data    = rd_data_q;
  assign o_bus_req           = req_q;
  assign o_bus_we            = we_q;
  assign o_bus_addr          = addr_q;
  assign o_bus_be            = be_q;
  assign o_bus_wdata         = wdata_q;

endmodule

// File: tb/tb_riscv_dmem_bus_bridge.sv
// ----------------------------------------------------------------------------
// tb_riscv_dmem_bus_bridge
//
// Drives the bridge as the CPU and as the bus responder. Each access is
// described by its grant delay, response delay and response contents; the
// reference model predicts the stall length, retired load data, error pulse
// and sticky error from those parameters alone.
// ----------------------------------------------------------------------------
module tb_riscv_dmem_bus_bridge;

  localparam int XLEN = 32;
  localparam int TO   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] br_addr;
  logic            br_wr_en;
  logic            br_rd_en;
  logic [3:0]      br_be;
  logic [XLEN-1:0] br_wdata;
  logic [XLEN-1:0] br_rdata;
  logic            br_stall;
  logic            br_err;
  logic            br_sticky;
  logic            bus_req;
  logic            bus_we;
  logic [XLEN-1:0] bus_addr;
  logic [3:0]      bus_be;
  logic [XLEN-1:0] bus_wdata;
  logic            bus_gnt;
  logic            bus_rvalid;
  logic [XLEN-1:0] bus_rdata;
  logic            bus_err;

  always #5 clk = ~clk;

  riscv_dmem_bus_bridge #(
    .XLEN(XLEN),
    .TIMEOUT_CYCLES(TO),
    .TO_W(3)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_bridge_addr(br_addr),
    .i_bridge_wr_en(br_wr_en),
    .i_bridge_rd_en(br_rd_en),
    .i_bridge_byte_sel(br_be),
    .i_bridge_wr_data(br_wdata),
    .o_bridge_rd_data(br_rdata),
    .o_bridge_stall(br_stall),
    .o_bridge_err(br_err),
    .o_bridge_err_sticky(br_sticky),
    .o_bus_req(bus_req),
    .o_bus_we(bus_we),
    .o_bus_addr(bus_addr),
    .o_bus_be(bus_be),
    .o_bus_wdata(bus_wdata),
    .i_bus_gnt(bus_gnt),
    .i_bus_rvalid(bus_rvalid),
    .i_bus_rdata(bus_rdata),
    .i_bus_err(bus_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic [XLEN-1:0] exp_rd;
  logic            exp_sticky;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One CPU access. Called at posedge+1; returns at posedge+1 of the cycle
  // after DONE with the access inputs still applied.
  //   g    : REQ cycles without grant before the granting cycle
  //   same : rvalid together with gnt
  //   rdly : RSP cycle (1-based) carrying rvalid; > TO means it never comes
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] wd,
                           input int g, input bit same, input int rdly,
                           input logic [31:0] rdata, input bit berr);
    int  req_cnt   = 0;
    int  k         = 0;
    int  stall_cnt = 0;
    bit  granted   = 0;
    bit  done      = 0;
    bit  to_hit;
    bit  exp_err;
    int  exp_stall;
    logic [68:0] exp_fields;

    to_hit    = !same && (rdly > TO);
    exp_err   = to_hit | berr;
    exp_stall = same ? (2 + g) : (2 + g + (to_hit ? TO : rdly));
    exp_fields = {a[31:2], 2'b00, be, wr, wd};

    br_rd_en = rd;
    br_wr_en = wr;
    br_addr  = a;
    br_be    = be;
    br_wdata = wd;

    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = $urandom;
      bus_err    = 1'($urandom);
      if (cyc == 0) check("req_low_first_cycle", 72'(bus_req), 72'(1'b0));
      if (bus_req) begin
        req_cnt++;
        check("bus_fields", 72'({bus_addr, bus_be, bus_we, bus_wdata}), 72'(exp_fields));
        if (req_cnt == g + 1) begin
          bus_gnt = 1'b1;
          granted = 1;
          if (same) begin
            bus_rvalid = 1'b1;
            bus_rdata  = rdata;
            bus_err    = berr;
          end
        end
      end else if (granted) begin
        k++;
        if (!same && k == rdly) begin
          bus_rvalid = 1'b1;
          bus_rdata  = rdata;
          bus_err    = berr;
        end
      end
      #1;
      if (br_stall) begin
        stall_cnt++;
      end else if (cyc > 0) begin
        done = 1;
        if (to_hit) exp_rd = '0;
        else if (!wr) exp_rd = rdata;
        check("stall_cycles", 72'(stall_cnt), 72'(exp_stall));
        check("done_rd_data", 72'(br_rdata), 72'(exp_rd));
        check("done_err",     72'(br_err),   72'(exp_err));
        check("done_req_low", 72'(bus_req),  72'(1'b0));
      end else begin
        check("stall_first_cycle", 72'(br_stall), 72'(1'b1));
      end
      if (!done) begin
        @(posedge clk);
        #1;
      end
    end
    if (!done) check("access_hang", 72'(0), 72'(1));
    @(posedge clk);
    #1;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    exp_sticky = exp_sticky | exp_err;
    check("sticky",        72'(br_sticky), 72'(exp_sticky));
    check("err_after_done", 72'(br_err),   72'(1'b0));
    $display("txn %s addr=%h be=%h wd=%h g=%0d same=%0d rdly=%0d stall=%0d rd=%h err=%0d",
             wr ? "ST" : "LD", a, be, wd, g, same, rdly, stall_cnt, br_rdata, exp_err);
  endtask

  // Idle cycles with no CPU access; optional stray bus strobes must be ignored.
  task automatic idle(input int n, input bit stray);
    br_rd_en = 1'b0;
    br_wr_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus_gnt    = stray & 1'($urandom);
      bus_rvalid = stray & 1'($urandom);
      bus_rdata  = $urandom;
      bus_err    = 1'($urandom);
      #1;
      check("idle_stall",   72'(br_stall), 72'(1'b0));
      check("idle_req",     72'(bus_req),  72'(1'b0));
      check("idle_err",     72'(br_err),   72'(1'b0));
      check("idle_rd_data", 72'(br_rdata), 72'(exp_rd));
      @(posedge clk);
      #1;
    end
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    br_addr    = '0;
    br_wr_en   = 1'b0;
    br_rd_en   = 1'b0;
    br_be      = '0;
    br_wdata   = '0;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    bus_err    = 1'b0;
    exp_rd     = '0;
    exp_sticky = 1'b0;

    // Reset state.
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_bus_fields", 72'({bus_req, bus_we, bus_addr, bus_be, bus_wdata}), 72'(0));
    check("rst_rd_data", 72'(br_rdata), 72'(0));
    check("rst_err",     72'({br_err, br_sticky}), 72'(0));
    check("rst_stall_noacc", 72'(br_stall), 72'(1'b0));
    br_rd_en = 1'b1;
    #1;
    check("rst_stall_acc", 72'(br_stall), 72'(1'b1));
    br_rd_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2, 1);

    // Load with byte offset, grant in first REQ cycle, rvalid in RSP cycle 2.
    do_access(1, 0, 32'h0000_1006, 4'b1100, 32'h0, 0, 0, 2, 32'hA5A5_1234, 0);
    idle(1, 0);
    // Store with grant held off for 5 cycles; rd_data must stay put.
    do_access(0, 1, 32'h0000_0020, 4'hF, 32'hDEAD_BEEF, 5, 0, 1, 32'h1111_2222, 0);
    idle(1, 0);
    // Timeout load, then a good load with sticky still set.
    do_access(1, 0, 32'h0000_0040, 4'hF, 32'h0, 0, 0, 100, 32'h3333_4444, 0);
    do_access(1, 0, 32'h0000_0044, 4'hF, 32'h0, 1, 0, 1, 32'h5555_6666, 0);
    // rvalid in the timeout cycle wins.
    do_access(1, 0, 32'h0000_0048, 4'h3, 32'h0, 0, 0, TO, 32'h7777_8888, 0);
    // Same-cycle gnt+rvalid, then back-to-back load held through DONE.
    do_access(1, 0, 32'h0000_0100, 4'hF, 32'h0, 0, 1, 1, 32'h0BAD_F00D, 0);
    do_access(1, 0, 32'h0000_0104, 4'hF, 32'h0, 0, 0, 1, 32'hCAFE_0001, 0);
    // Store with bus error, then stray strobes in IDLE.
    do_access(0, 1, 32'h0000_0200, 4'h1, 32'h0000_00AB, 0, 0, 3, 32'h9999_9999, 1);
    idle(3, 1);
    // rd_en and wr_en together behave as a store.
    do_access(1, 1, 32'h0000_0303, 4'h6, 32'h1234_5678, 2, 0, 2, 32'hEEEE_EEEE, 0);

    // Randomized accesses.
    for (int t = 0; t < 40; t++) begin
      int sel;
      sel = $urandom_range(0, 2);
      do_access(sel != 1, sel != 0, $urandom, 4'($urandom), $urandom,
                $urandom_range(0, 3), ($urandom_range(0, 4) == 0),
                $urandom_range(1, 6), $urandom, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2), 1);
    end

    // Reset in the middle of RSP.
    idle(1, 0);
    br_rd_en = 1'b1;
    br_addr  = 32'h0000_0500;
    br_be    = 4'hF;
    for (int i = 0; i < 5 && !bus_req; i++) begin
      @(posedge clk); #1;
    end
    check("rst_test_req_seen", 72'(bus_req), 72'(1'b1));
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_req",    72'(bus_req),   72'(1'b0));
    check("midrst_stall",  72'(br_stall),  72'(1'b1));
    check("midrst_sticky", 72'(br_sticky), 72'(1'b0));
    check("midrst_rd",     72'(br_rdata),  72'(0));
    br_rd_en = 1'b0;
    #1;
    check("midrst_stall_noacc", 72'(br_stall), 72'(1'b0));
    @(posedge clk); #1;
    rst        = 1'b0;
    exp_rd     = '0;
    exp_sticky = 1'b0;
    idle(1, 0);
    do_access(1, 0, 32'h0000_0600, 4'hF, 32'h0, 1, 0, 2, 32'hFACE_B00C, 0);
    idle(2, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
